alu: RTL and testbench

Combinational WIDTH-bit arithmetic/logic unit with a clocked processor-status (flag) register. It computes the datapath result and the condition flags from two operands and a 4-bit opcode extension. It also holds the last arithmetic flags so that carry-chained operations (ADDC/SUBC) can use them. It sits in the execute stage between the register-file read ports and write-back.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_addsub.sv | 46 ++++
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 115 +++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcode encodings and bit positions in the
// processor-status (flag) byte {3'b0, Z, C, F, N, L}.
package alu_pkg;

    localparam logic [3:0] OP_MOV  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_OR   = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_ADDC = 4'b0110;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_SUBC = 4'b1010;
    localparam logic [3:0] OP_CMP  = 4'b1011;

    localparam int PSR_L = 0;
    localparam int PSR_N = 1;
    localparam int PSR_F = 2;
    localparam int PSR_C = 3;
    localparam int PSR_Z = 4;

endpackage

// File: rtl/alu_addsub.sv
// WIDTH-bit adder/subtractor with carry-in.
//   a_i, b_i  : operands
//   cin_i     : carry-in (add) or borrow-in (subtract)
//   sub_i     : 1 = a - b - cin, 0 = a + b + cin
//   sum_o     : WIDTH-bit result, modulo 2^WIDTH
//   carry_o   : carry out (add) or borrow out (subtract)
//   ovf_o     : signed overflow
module alu_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o
);

    logic [WIDTH:0] ext;

    // One extra bit on top: for subtraction it goes to 1 exactly when the
    // unsigned difference wraps, i.e. it is the borrow.
    always_comb begin
        if (sub_i) begin
            ext = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, cin_i};
        end else begin
            ext = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
        end
    end

    assign sum_o   = ext[WIDTH-1:0];
    assign carry_o = ext[WIDTH];

    // Add overflows when operand signs match and the result sign differs;
    // subtract overflows when operand signs differ and the result sign
    // differs from a.
    always_comb begin
        if (sub_i) begin
            ovf_o = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (sum_o[WIDTH-1] ^ a_i[WIDTH-1]);
        end else begin
            ovf_o = ~(a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (sum_o[WIDTH-1] ^ a_i[WIDTH-1]);
        end
    end

endmodule

// File: rtl/alu.sv
// Execute-stage ALU: combinational result and flags, plus a flag register
// that captures arithmetic flags so ADDC/SUBC can chain through the carry.
//   clk, reset : flag register clock and asynchronous active-high clear
//   a, b       : operands (b is the destination register value)
//   alucont    : operation select
//   result     : combinational result
//   PSR        : combinational flags {3'b0, Z, C, F, N, L}
//   psr_q      : registered flags, same layout
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alucont,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       PSR,
    output logic [7:0]       psr_q
);

    logic             is_add;
    logic             is_sub;
    logic             is_arith;
    logic             use_cin;
    logic             cin;
    logic [WIDTH-1:0] as_sum;
    logic             as_carry;
    logic             as_ovf;
    logic [7:0]       flags_d;
    logic [7:0]       flags_q;

    assign is_add   = (alucont == OP_ADD) || (alucont == OP_ADDC);
    assign is_sub   = (alucont == OP_SUB) || (alucont == OP_SUBC) || (alucont == OP_CMP);
    assign is_arith = is_add || is_sub;
    assign use_cin  = (alucont == OP_ADDC) || (alucont == OP_SUBC);
    // Carry-in comes from the registered flags only, so there is no loop;
    // during reset flags_q is already cleared, giving carry-in 0.
    assign cin      = use_cin & flags_q[PSR_C];

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .sub_i   (is_sub),
        .sum_o   (as_sum),
        .carry_o (as_carry),
        .ovf_o   (as_ovf)
    );

    always_comb begin
        result = '0;
        unique case (alucont)
            OP_MOV:                    result = a;
            OP_AND:                    result = a & b;
            OP_OR:                     result = a | b;
            OP_XOR:                    result = a ^ b;
            OP_ADD, OP_ADDC,
            OP_SUB, OP_SUBC:           result = as_sum;
            OP_CMP:                    result = b;
            default:                   result = '0;
        endcase
    end

    // Z and N come from the adder output rather than result so that CMP
    // reports the difference even though it passes b through.
    always_comb begin
        flags_d = 8'h00;
        if (is_arith) begin
            flags_d[PSR_Z] = (as_sum == '0);
            flags_d[PSR_N] = as_sum[WIDTH-1];
            flags_d[PSR_C] = as_carry;
            flags_d[PSR_F] = as_ovf;
            flags_d[PSR_L] = is_sub && (a < b);
        end
    end

    assign PSR = flags_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= 8'h00;
        end else if (is_arith) begin
            flags_q <= flags_d;
        end
    end

    assign psr_q = flags_q;

endmodule

// File: tb/tb_alu.sv
module tb_alu;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alucont;
    logic [WIDTH-1:0] result;
    logic [7:0]       PSR;
    logic [7:0]       psr_q;

    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .alucont (alucont),
        .result  (result),
        .PSR     (PSR),
        .psr_q   (psr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operation at the falling edge and check the combinational
    // outputs 1 time unit later.
    task automatic step(input string tag, input logic [3:0] op,
                        input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] exp_res, input logic [7:0] exp_psr);
        @(negedge clk);
        alucont = op;
        a       = av;
        b       = bv;
        #1;
        check({tag, ".result"}, result, exp_res);
        check({tag, ".PSR"}, {8'h00, PSR}, {8'h00, exp_psr});
    endtask

    initial begin
        reset   = 1'b1;
        a       = '0;
        b       = '0;
        alucont = 4'b0000;
        #1;
        check("reset.psr_q", {8'h00, psr_q}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        step("MOV",  4'b0000, 16'h1234, 16'h5678, 16'h1234, 8'h00);
        step("AND",  4'b0001, 16'hFFFF, 16'hAAAA, 16'hAAAA, 8'h00);
        step("XOR",  4'b0011, 16'hAAAA, 16'hAAAA, 16'h0000, 8'h00);
        step("OR",   4'b0010, 16'h5555, 16'hAAAA, 16'hFFFF, 8'h00);
        step("UNDEF",4'b0100, 16'h1234, 16'h1234, 16'h0000, 8'h00);
        check("psr_q_after_logic", {8'h00, psr_q}, 16'h0000);

        // Carry-out sets C in the flag register.
        step("ADD_ZC", 4'b0101, 16'hFFFF, 16'h0001, 16'h0000, 8'h18);
        // Logic op across an edge must leave psr_q alone.
        step("AND_hold", 4'b0001, 16'h0F0F, 16'h00FF, 16'h000F, 8'h00);
        @(posedge clk);
        #1;
        check("psr_q_hold", {8'h00, psr_q}, 16'h0018);
        // SUBC with borrow-in 1: 5 - 2 - 1 = 2.
        step("SUBC", 4'b1010, 16'h0005, 16'h0002, 16'h0002, 8'h00);

        step("ADD_FN", 4'b0101, 16'h7000, 16'h4000, 16'hB000, 8'h06);
        step("ADD_CF", 4'b0101, 16'h8000, 16'h8001, 16'h0001, 8'h0C);
        step("SUB_Z",  4'b1001, 16'h8000, 16'h8000, 16'h0000, 8'h10);
        step("SUB_CNL",4'b1001, 16'h0003, 16'h0006, 16'hFFFD, 8'h0B);
        step("CMP_lt", 4'b1011, 16'h0003, 16'h0006, 16'h0006, 8'h0B);
        step("CMP_eq", 4'b1011, 16'h0005, 16'h0005, 16'h0005, 8'h10);

        // Flag register and carry chain.
        step("SUB_all", 4'b1001, 16'h7FFF, 16'hFFFF, 16'h8000, 8'h0F);
        @(posedge clk);
        #1;
        check("psr_q_chain", {8'h00, psr_q}, 16'h000F);
        alucont = 4'b0110;
        a       = 16'h0001;
        b       = 16'h0001;
        #1;
        check("ADDC_cin1.result", result, 16'h0003);
        check("ADDC_cin1.PSR", {8'h00, PSR}, 16'h0000);
        reset = 1'b1;
        #1;
        check("async_reset.psr_q", {8'h00, psr_q}, 16'h0000);
        check("ADDC_reset.result", result, 16'h0002);
        @(negedge clk);
        reset = 1'b0;

        step("SUB_F", 4'b1001, 16'h8000, 16'h7FFF, 16'h0001, 8'h04);
        @(posedge clk);
        #1;
        check("psr_q_SUB_F", {8'h00, psr_q}, 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
